// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, controller
// state encoding, accumulator source select and ALU operation codes.
package cpu_pkg;

  // Instruction opcodes (IR[7:4]); 4'hA..4'hE are undefined.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_LDI   = 4'h7;
  localparam logic [3:0] OP_JMP   = 4'h8;
  localparam logic [3:0] OP_JZ    = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hF;

  // Accumulator write-data source.
  localparam logic [1:0] ACC_SRC_ALU = 2'd0;
  localparam logic [1:0] ACC_SRC_MEM = 2'd1;
  localparam logic [1:0] ACC_SRC_IMM = 2'd2;

  // ALU operations; the ALU opcodes 3..6 map onto these as opcode-3.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  // Controller states.
  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_LOADIR = 3'd2,
    S_DECODE = 3'd3,
    S_MEMRD  = 3'd4,
    S_EXEC   = 3'd5,
    S_MEMWR  = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // True for the opcodes whose operand comes from memory and goes through the ALU.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // True for every opcode the CPU implements.
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op <= OP_JZ) || (op == OP_HALT);
  endfunction

  // ALU operation code for an ALU opcode (ADD..OR -> 0..3).
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    logic [3:0] diff;
    diff = op - OP_ADD;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU.
// Sequences fetch -> IR load -> decode -> (memory read/execute | memory write)
// and decodes the datapath strobes from the current state (plus opcode in
// DECODE/EXEC). Outputs are purely state-decoded so an asynchronous reset
// removes every enable immediately.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       LoadIR,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       load_acc,
  output logic [1:0] acc_src,
  output logic [2:0] alu_op,
  output logic       halted,
  output logic       illegal_op
);

  localparam int CW = $clog2(MEM_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_cnt_next;

  // State and memory-wait counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_RESET;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and wait-counter logic; counter runs only in FETCH/MEMRD.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    case (state)
      S_RESET: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = S_LOADIR;
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      S_LOADIR: begin
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == OP_STORE) begin
          state_next = S_MEMWR;
        end else if (opcode == OP_LOAD || is_alu_op(opcode)) begin
          state_next = S_MEMRD;
        end else if (opcode == OP_HALT) begin
          state_next = S_HALT;
        end else begin
          // NOP, LDI, JMP, JZ and undefined opcodes finish here.
          state_next = S_FETCH;
        end
      end
      S_MEMRD: begin
        if (wait_cnt == WAIT_LAST) begin
          state_next = S_EXEC;
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end
      S_EXEC: begin
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        state_next = S_FETCH;
      end
      S_HALT: begin
        state_next = S_HALT;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  // Datapath strobes decoded from the current state (and opcode where needed).
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr_sel   = 1'b0;
    LoadIR     = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    load_acc   = 1'b0;
    acc_src    = ACC_SRC_ALU;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      S_RESET: begin
        halted = 1'b0;
      end
      S_FETCH: begin
        mem_read = 1'b1;
        addr_sel = 1'b0;
      end
      S_LOADIR: begin
        LoadIR = 1'b1;
        pc_inc = 1'b1;
      end
      S_DECODE: begin
        case (opcode)
          OP_LDI: begin
            load_acc = 1'b1;
            acc_src  = ACC_SRC_IMM;
          end
          OP_JMP: begin
            pc_load = 1'b1;
          end
          OP_JZ: begin
            pc_load = zero_flag;
          end
          default: begin
            illegal_op = ~is_defined_op(opcode);
          end
        endcase
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        addr_sel = 1'b1;
      end
      S_EXEC: begin
        load_acc = 1'b1;
        if (opcode == OP_LOAD) begin
          acc_src = ACC_SRC_MEM;
        end else begin
          acc_src = ACC_SRC_ALU;
          alu_op  = alu_code(opcode);
        end
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        addr_sel  = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed, table-driven bench for cpu_controller. One instance uses
// MEM_WAIT=1, a second uses MEM_WAIT=3; both share clock and inputs.
module tb_cpu_controller;

  logic       clock;
  logic       reset;
  logic [3:0] opcode;
  logic       zero_flag;

  logic       mr1, mw1, as1, ir1, pi1, pl1, la1, h1, il1;
  logic [1:0] src1;
  logic [2:0] aop1;
  logic       mr3, mw3, as3, ir3, pi3, pl3, la3, h3, il3;
  logic [1:0] src3;
  logic [2:0] aop3;

  int checks;
  int failures;

  cpu_controller #(.MEM_WAIT(1)) dut1 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
    .mem_read(mr1), .mem_write(mw1), .addr_sel(as1), .LoadIR(ir1),
    .pc_inc(pi1), .pc_load(pl1), .load_acc(la1), .acc_src(src1),
    .alu_op(aop1), .halted(h1), .illegal_op(il1)
  );

  cpu_controller #(.MEM_WAIT(3)) dut3 (
    .clock(clock), .reset(reset), .opcode(opcode), .zero_flag(zero_flag),
    .mem_read(mr3), .mem_write(mw3), .addr_sel(as3), .LoadIR(ir3),
    .pc_inc(pi3), .pc_load(pl3), .load_acc(la3), .acc_src(src3),
    .alu_op(aop3), .halted(h3), .illegal_op(il3)
  );

  // Packed view: {mem_read,mem_write,addr_sel,LoadIR,pc_inc,pc_load,load_acc,acc_src,alu_op,halted,illegal_op}
  logic [13:0] obs1, obs3;
  assign obs1 = {mr1, mw1, as1, ir1, pi1, pl1, la1, src1, aop1, h1, il1};
  assign obs3 = {mr3, mw3, as3, ir3, pi3, pl3, la3, src3, aop3, h3, il3};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic        zf;
    logic [13:0] exp;
  } vec_t;

  vec_t tab [0:127];
  int   ntab;

  function automatic logic [13:0] mk(input logic mr, input logic mw, input logic as,
                                     input logic ir, input logic pi, input logic pl,
                                     input logic la, input logic [1:0] src,
                                     input logic [2:0] aop, input logic h, input logic il);
    return {mr, mw, as, ir, pi, pl, la, src, aop, h, il};
  endfunction

  logic [13:0] e_f, e_l, e_z, e_mr, e_mw, e_h, e_pl, e_ldi, e_ill;

  task automatic add(input logic [3:0] op, input logic zf, input logic [13:0] e);
    tab[ntab].op  = op;
    tab[ntab].zf  = zf;
    tab[ntab].exp = e;
    ntab++;
  endtask

  // ALU-style instruction through memory read and execute (MEM_WAIT=1).
  task automatic add_memop(input logic [3:0] op, input logic [1:0] src, input logic [2:0] aop);
    add(op, 1'b0, e_f);
    add(op, 1'b0, e_l);
    add(op, 1'b0, e_z);
    add(op, 1'b0, e_mr);
    add(op, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, src, aop, 1'b0, 1'b0));
  endtask

  task automatic add_short(input logic [3:0] op, input logic zf, input logic [13:0] dec);
    add(op, zf, e_f);
    add(op, zf, e_l);
    add(op, zf, dec);
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // One table row per cycle: drive inputs on the falling edge, compare 1 time unit later.
  task automatic run_tab(input int first, input int last, input bit use3);
    for (int i = first; i < last; i++) begin
      @(negedge clock);
      opcode    = tab[i].op;
      zero_flag = tab[i].zf;
      #1;
      checks++;
      if ((use3 ? obs3 : obs1) !== tab[i].exp) begin
        failures++;
        $display("FAIL vec%0d op=%h zf=%b got=%b expected=%b", i, tab[i].op, tab[i].zf,
                 (use3 ? obs3 : obs1), tab[i].exp);
      end
    end
  endtask

  // Structural invariants on both instances, sampled mid-cycle.
  always begin
    @(negedge clock);
    #2;
    if (!reset) begin
      checks++;
      if ((mr1 & mw1) | (pi1 & pl1) | (mr3 & mw3) | (pi3 & pl3)) begin
        failures++;
        $display("FAIL invariant got mr1/mw1/pi1/pl1=%b%b%b%b mr3/mw3/pi3/pl3=%b%b%b%b expected no pair high",
                 mr1, mw1, pi1, pl1, mr3, mw3, pi3, pl3);
      end
    end
  end

  int a_end, c_end, b_end;

  initial begin
    checks    = 0;
    failures  = 0;
    ntab      = 0;
    reset     = 1'b1;
    opcode    = 4'h0;
    zero_flag = 1'b0;

    e_f   = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    e_l   = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    e_z   = 14'd0;
    e_mr  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    e_mw  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    e_h   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 1'b0);
    e_pl  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0);
    e_ldi = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0);
    e_ill = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b1);

    // Table A: MEM_WAIT=1 program, one row per cycle starting at the first FETCH.
    add_short(4'h7, 1'b0, e_ldi);           // LDI: 3 cycles
    add(4'h7, 1'b0, e_f);                   // next fetch right after
    add(4'h4, 1'b0, e_l);
    add(4'h4, 1'b0, e_z);
    add(4'h4, 1'b0, e_mr);
    add(4'h4, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0, 1'b0));
    add_short(4'h9, 1'b1, e_pl);            // JZ taken
    add_short(4'h9, 1'b0, e_z);             // JZ not taken
    add_short(4'h8, 1'b0, e_pl);            // JMP
    add(4'h2, 1'b0, e_f);                   // STORE: 4 cycles
    add(4'h2, 1'b0, e_l);
    add(4'h2, 1'b0, e_z);
    add(4'h2, 1'b0, e_mw);
    add_memop(4'h3, 2'd0, 3'd0);            // ADD
    add_memop(4'h5, 2'd0, 3'd2);            // AND
    add_memop(4'h6, 2'd0, 3'd3);            // OR
    add_memop(4'h1, 2'd1, 3'd0);            // LOAD
    add_short(4'h0, 1'b0, e_z);             // NOP
    add_short(4'hB, 1'b0, e_ill);           // undefined
    add_short(4'hA, 1'b0, e_ill);           // undefined
    add_short(4'hF, 1'b0, e_z);             // HALT decode
    add(4'hF, 1'b0, e_h);
    add(4'h7, 1'b0, e_h);                   // opcode change ignored while halted
    add(4'h9, 1'b1, e_h);
    a_end = ntab;
    // Table C: STORE up to its write cycle, then reset is asserted mid-cycle.
    add(4'h2, 1'b0, e_f);
    add(4'h2, 1'b0, e_l);
    add(4'h2, 1'b0, e_z);
    add(4'h2, 1'b0, e_mw);
    c_end = ntab;
    // Table B: MEM_WAIT=3 LOAD, 9 cycles then the next fetch.
    add(4'h1, 1'b0, e_f);
    add(4'h1, 1'b0, e_f);
    add(4'h1, 1'b0, e_f);
    add(4'h1, 1'b0, e_l);
    add(4'h1, 1'b0, e_z);
    add(4'h1, 1'b0, e_mr);
    add(4'h1, 1'b0, e_mr);
    add(4'h1, 1'b0, e_mr);
    add(4'h1, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b0));
    add(4'h1, 1'b0, e_f);
    b_end = ntab;

    // Reset held 3 cycles, outputs all zero; still zero in S_RESET after release.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_hold_w1", obs1, 14'd0);
    check("reset_hold_w3", obs3, 14'd0);
    reset = 1'b0;
    #1;
    check("s_reset_w1", obs1, 14'd0);
    check("s_reset_w3", obs3, 14'd0);

    run_tab(0, a_end, 1'b0);

    // Halted state is only left through reset.
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("halt_reset", obs1, 14'd0);
    @(negedge clock);
    reset = 1'b0;
    run_tab(a_end, c_end, 1'b0);
    // Now in S_MEMWR with mem_write high; assert reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check("memwr_async_mw", {13'd0, mw1}, 14'd0);
    check("memwr_async_all", obs1, 14'd0);

    @(negedge clock);
    reset = 1'b0;
    run_tab(c_end, b_end, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
